uart_tx_frame: RTL and testbench
================================

// Module: uart_tx_frame
// PURPOSE
//  UART transmit framer and serializer, the Tx-side counterpart of the Rx error-check path.
//  Accepts an 8-bit byte and a parity_type and shifts out one frame on tx_out:
//  start bit, 8 data bits LSB first, one parity slot, STOP_BITS stop bits.
//  Uses the same parity_type encoding the Rx side checks against; sits between the host interface and the pad.
// PARAMETERS
//  CLKS_PER_BIT  434  clk cycles per serial bit (50 MHz / 115200); legal >= 2
//  STOP_BITS     1    number of stop bits, 1 or 2
// PORTS
//  clk          in   1  system clock, all state on rising edge
//  reset_n      in   1  asynchronous, active-low reset
//  send         in   1  request to transmit; accepted only when busy==0
//  data_in      in   8  byte to transmit; latched on acceptance
//  parity_type  in   2  01=ODD, 10=EVEN, 00/11=no parity; latched on acceptance
//  tx_out       out  1  serial line, idle high
//  busy         out  1  high while a frame is in progress
//  done         out  1  one-cycle pulse at frame completion
// BEHAVIOUR
//  - Reset (async, any state): tx_out=1, busy=0, done=0, FSM=IDLE, counters=0, shift reg cleared.
//  - All outputs are registered; no combinational path from inputs to outputs.
//  - FSM states: IDLE -> START -> DATA -> PARITY -> STOP -> IDLE.
//  - IDLE: tx_out=1.
//    On a cycle with send==1 and busy==0: latch data_in and parity_type, go to START, set busy=1.
//  - Latency: tx_out drives 0 on the first cycle after the accepting edge.
//  - Bit timing: each bit slot holds tx_out for exactly CLKS_PER_BIT cycles.
//    A baud counter runs 0..CLKS_PER_BIT-1; the FSM and bit index advance on terminal count.
//  - DATA: 8 slots; bit index 0..7 selects latched data[idx], LSB first.
//    Leave DATA on terminal count with idx==7.
//  - PARITY: one slot, always present (11-bit frame when STOP_BITS=1).
//    EVEN (10): tx = ^data.  ODD (01): tx = ~^data.  00/11: tx = 1.
//  - STOP: STOP_BITS slots of tx_out=1.
//    On the final terminal count: FSM -> IDLE, busy -> 0, and done=1 for exactly that next cycle.
//  - Frame length: (10 + STOP_BITS) * CLKS_PER_BIT cycles, from the first start-bit cycle to busy deassertion.
//  - send while busy==1 is ignored and not queued.
//    data_in and parity_type changes while busy have no effect on the current frame.
//  - Back-to-back: send is sampled in the cycle busy==0 and done==1.
//    If it is high, the next start bit follows the last stop cycle with no idle gap.
//  - send held high continuously gives continuous frames.
//  - Reset mid-frame: tx_out returns to 1 immediately; the partial frame is abandoned.
//    The next accepted send starts a clean frame.
//  - Baud counter and bit index are sized to hold CLKS_PER_BIT-1 and 7; they never wrap past the terminal value.
// TESTING  (bench uses CLKS_PER_BIT=4, STOP_BITS=1 unless stated)
//  1. send 0xA5, parity_type=10 -> tx_out per 4-cycle slot: 0,1,0,1,0,0,1,0,1,0(par),1(stop).
//     busy high for 44 cycles, then done=1 for one cycle.
//  2. send 0xA5, parity_type=01 -> same frame with parity slot=1.
//     send 0x07, parity_type=10 -> parity slot=1.
//  3. send 0x00 with parity_type=00, then 0xFF with parity_type=11 -> parity slot=1 in both frames.
//  4. pulse send again at cycle 10 with data_in=0x3C; also change data_in mid-frame.
//     -> no effect; only the 0xA5 frame is sent; busy unaffected.
//  5. assert reset_n=0 during DATA idx 3 -> tx_out=1, busy=0 the same cycle.
//     After release, send 0x55 -> a correct full frame.
//  6. hold send=1 with STOP_BITS=2 -> frames of 48 cycles back-to-back.
//     done pulses every 48 cycles; start bit follows stop directly.

Source files
------------

// File: rtl/uart_tx_frame.sv
// UART transmit framer: start bit, 8 data bits LSB first, a parity slot and STOP_BITS stop bits.
// Every output is registered, so nothing on the pad side ever sees a combinational path from the host.
`timescale 1ns/1ps

module uart_tx_frame #(
  parameter int CLKS_PER_BIT = 434,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       send,
  input  logic [7:0] data_in,
  input  logic [1:0] parity_type,
  output logic       tx_out,
  output logic       busy,
  output logic       done
);

  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] baud_cnt;
  logic [CNT_W-1:0] baud_next;
  logic [2:0]       bit_idx;
  logic [2:0]       bit_idx_next;
  logic             stop_cnt;
  logic             stop_cnt_next;
  logic [7:0]       data_reg;
  logic [7:0]       data_next;
  logic [1:0]       ptype_reg;
  logic [1:0]       ptype_next;
  logic             tx_next;
  logic             busy_next;
  logic             done_next;
  logic             baud_last;
  logic             stop_last;

  assign baud_last = (baud_cnt == BAUD_LAST);
  assign stop_last = (stop_cnt == STOP_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      stop_cnt  <= 1'b0;
      data_reg  <= '0;
      ptype_reg <= '0;
      tx_out    <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_next;
      baud_cnt  <= baud_next;
      bit_idx   <= bit_idx_next;
      stop_cnt  <= stop_cnt_next;
      data_reg  <= data_next;
      ptype_reg <= ptype_next;
      tx_out    <= tx_next;
      busy      <= busy_next;
      done      <= done_next;
    end
  end

  // Every bit slot shares one baud counter; slot boundaries are its terminal count.
  always_comb begin
    state_next    = state;
    baud_next     = baud_cnt;
    bit_idx_next  = bit_idx;
    stop_cnt_next = stop_cnt;
    data_next     = data_reg;
    ptype_next    = ptype_reg;

    if (state != IDLE) begin
      baud_next = baud_last ? '0 : baud_cnt + CNT_W'(1);
    end

    case (state)
      IDLE: begin
        baud_next = '0;
        if (send && !busy) begin
          state_next    = START;
          data_next     = data_in;
          ptype_next    = parity_type;
          bit_idx_next  = '0;
          stop_cnt_next = 1'b0;
        end
      end
      START: begin
        if (baud_last) begin
          state_next   = DATA;
          bit_idx_next = '0;
        end
      end
      DATA: begin
        if (baud_last) begin
          if (bit_idx == 3'd7) begin
            state_next = PARITY;
          end else begin
            bit_idx_next = bit_idx + 3'd1;
          end
        end
      end
      PARITY: begin
        if (baud_last) begin
          state_next    = STOP;
          stop_cnt_next = 1'b0;
        end
      end
      STOP: begin
        if (baud_last) begin
          if (stop_last) begin
            state_next = IDLE;
          end else begin
            stop_cnt_next = stop_cnt + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs are computed from the upcoming state so the registered line changes on the slot edge.
  always_comb begin
    tx_next   = 1'b1;
    busy_next = (state_next != IDLE);
    done_next = (state == STOP) && baud_last && stop_last;

    case (state_next)
      START:  tx_next = 1'b0;
      DATA:   tx_next = data_next[bit_idx_next];
      PARITY: begin
        case (ptype_next)
          2'b10:   tx_next = ^data_next;
          2'b01:   tx_next = ~^data_next;
          default: tx_next = 1'b1;
        endcase
      end
      default: tx_next = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: directed and random frames on a 1-stop and a 2-stop instance,
// compared cycle by cycle against a frame built from the protocol rules.
`timescale 1ns/1ps

module tb_uart_tx_frame;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       send = 1'b0;
  logic       sel = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [1:0] parity_type = 2'b00;
  logic       send_a;
  logic       send_b;
  logic       tx_a, busy_a, done_a;
  logic       tx_b, busy_b, done_b;
  logic       tx_obs, busy_obs, done_obs;

  int checks = 0;
  int passed = 0;
  bit exp_bits[$];

  always #5 clk = ~clk;

  assign send_a   = send & ~sel;
  assign send_b   = send & sel;
  assign tx_obs   = sel ? tx_b : tx_a;
  assign busy_obs = sel ? busy_b : busy_a;
  assign done_obs = sel ? done_b : done_a;

  uart_tx_frame #(.CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut_a (
    .clk(clk), .reset_n(reset_n), .send(send_a), .data_in(data_in),
    .parity_type(parity_type), .tx_out(tx_a), .busy(busy_a), .done(done_a)
  );

  uart_tx_frame #(.CLKS_PER_BIT(CPB), .STOP_BITS(2)) dut_b (
    .clk(clk), .reset_n(reset_n), .send(send_b), .data_in(data_in),
    .parity_type(parity_type), .tx_out(tx_b), .busy(busy_b), .done(done_b)
  );

  // Frame as a list of bit slots: start, data LSB first, parity, stop bits.
  function automatic void build_frame(input logic [7:0] d, input logic [1:0] p, input int stops);
    int ones;
    ones = 0;
    exp_bits.delete();
    exp_bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) begin
      exp_bits.push_back(d[i]);
      ones += int'(d[i]);
    end
    if (p == 2'b10) exp_bits.push_back(1'(ones % 2));
    else if (p == 2'b01) exp_bits.push_back(1'(1 - (ones % 2)));
    else exp_bits.push_back(1'b1);
    for (int i = 0; i < stops; i++) exp_bits.push_back(1'b1);
  endfunction

  task automatic check_output(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("[TB] FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_output("idle tx", tx_obs, 1'b1);
      check_output("idle busy", busy_obs, 1'b0);
      check_output("idle done", done_obs, 1'b0);
    end
  endtask

  // Called at a negedge with the selected DUT idle; ends on the done cycle so a following
  // call requests the next frame back-to-back.
  task automatic apply_stimulus(input logic [7:0] d, input logic [1:0] p, input bit noise, input bit hold);
    int stops;
    int flen;
    stops = sel ? 2 : 1;
    flen  = (10 + stops) * CPB;
    build_frame(d, p, stops);
    send        = 1'b1;
    data_in     = d;
    parity_type = p;
    for (int c = 0; c <= flen; c++) begin
      @(negedge clk);
      if (c == 0 && !hold) send = 1'b0;
      if (c < flen) begin
        check_output($sformatf("tx d=%h c=%0d", d, c), tx_obs, exp_bits[c / CPB]);
        check_output($sformatf("busy d=%h c=%0d", d, c), busy_obs, 1'b1);
        check_output($sformatf("done d=%h c=%0d", d, c), done_obs, 1'b0);
      end else begin
        check_output($sformatf("end tx d=%h", d), tx_obs, 1'b1);
        check_output($sformatf("end busy d=%h", d), busy_obs, 1'b0);
        check_output($sformatf("end done d=%h", d), done_obs, 1'b1);
      end
      if (noise && c < flen) begin
        if (!hold) send = 1'($urandom_range(0, 1));
        data_in     = 8'($urandom);
        parity_type = 2'($urandom);
        if (c == 10) begin
          send    = 1'b1;
          data_in = 8'h3C;
        end
      end
      if (c == flen && !hold) send = 1'b0;
    end
  endtask

  initial begin
    logic [7:0] rd;
    logic [1:0] rp;

    $display("[TB] reset");
    repeat (2) @(negedge clk);
    check_output("reset tx_a", tx_a, 1'b1);
    check_output("reset busy_a", busy_a, 1'b0);
    check_output("reset done_a", done_a, 1'b0);
    check_output("reset tx_b", tx_b, 1'b1);
    check_output("reset busy_b", busy_b, 1'b0);
    check_output("reset done_b", done_b, 1'b0);
    reset_n = 1'b1;
    idle_cycles(2);

    $display("[TB] even/odd/none parity frames");
    apply_stimulus(8'hA5, 2'b10, 1'b0, 1'b0);
    idle_cycles(2);
    apply_stimulus(8'hA5, 2'b01, 1'b0, 1'b0);
    idle_cycles(1);
    apply_stimulus(8'h07, 2'b10, 1'b0, 1'b0);
    apply_stimulus(8'h00, 2'b00, 1'b0, 1'b0);
    apply_stimulus(8'hFF, 2'b11, 1'b0, 1'b0);
    idle_cycles(1);

    $display("[TB] send and data changes while busy");
    apply_stimulus(8'hA5, 2'b10, 1'b1, 1'b0);
    idle_cycles(2);

    $display("[TB] random frames");
    for (int i = 0; i < 6; i++) begin
      rd = 8'($urandom);
      rp = 2'($urandom);
      apply_stimulus(rd, rp, 1'b1, 1'b0);
      if (i % 2 == 1) idle_cycles(1);
    end
    idle_cycles(1);

    $display("[TB] reset during data bit 3");
    build_frame(8'h96, 2'b10, 1);
    send        = 1'b1;
    data_in     = 8'h96;
    parity_type = 2'b10;
    for (int c = 0; c < 18; c++) begin
      @(negedge clk);
      if (c == 0) send = 1'b0;
    end
    check_output("pre-reset tx", tx_obs, exp_bits[17 / CPB]);
    check_output("pre-reset busy", busy_obs, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    check_output("mid-reset tx", tx_obs, 1'b1);
    check_output("mid-reset busy", busy_obs, 1'b0);
    check_output("mid-reset done", done_obs, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    idle_cycles(2);
    apply_stimulus(8'h55, 2'b10, 1'b0, 1'b0);
    idle_cycles(1);

    $display("[TB] continuous send, two stop bits");
    sel = 1'b1;
    idle_cycles(1);
    for (int i = 0; i < 4; i++) begin
      rd = 8'($urandom);
      rp = 2'($urandom);
      apply_stimulus(rd, rp, 1'b1, 1'b1);
    end
    apply_stimulus(8'h3C, 2'b01, 1'b0, 1'b0);
    idle_cycles(2);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
